// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: RGB332 field layout, rounding constant,
// fill-stage FSM states and the address width used by ROM, RAM and VGA logic.
// Latency: n/a (definitions only). Backpressure: n/a.
package fb_pkg;

  localparam int ADDR_W = 19;

  // RGB332 layout: R=[7:5], G=[4:2], B=[1:0]
  localparam int R_LSB = 5;
  localparam int R_W   = 3;
  localparam int G_LSB = 2;
  localparam int G_W   = 3;
  localparam int B_LSB = 0;
  localparam int B_W   = 2;

  // Added before the >>2 so a 4-sample average rounds half-up
  localparam int RND = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/rgb332_avg4.sv
// Per-channel accumulate/round of four RGB332 samples into one averaged pixel.
// Latency: combinational result on the last sample; sums held in flops between samples.
// Backpressure: none; one sample accepted whenever sample_vld is high.
// Ports: clk/reset, sample_vld + sample (RGB332), clear (first sample of a
//        block), last (fourth sample); pix_vld/pix_dat valid with the last sample.
module rgb332_avg4
  import fb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_vld,
  input  logic [7:0] sample,
  input  logic       clear,
  input  logic       last,
  output logic       pix_vld,
  output logic [7:0] pix_dat
);

  logic [4:0] r_acc_q, r_acc_d, r_sum, r_rnd;
  logic [4:0] g_acc_q, g_acc_d, g_sum, g_rnd;
  logic [3:0] b_acc_q, b_acc_d, b_sum, b_rnd;

  always_comb begin
    // clear drops the previous block's partial sum so the first sample starts fresh
    r_sum = (clear ? 5'd0 : r_acc_q) + 5'(sample[R_LSB +: R_W]);
    g_sum = (clear ? 5'd0 : g_acc_q) + 5'(sample[G_LSB +: G_W]);
    b_sum = (clear ? 4'd0 : b_acc_q) + 4'(sample[B_LSB +: B_W]);
    // max sums 28/28/12 plus 2 still fit in 5/5/4 bits
    r_rnd = r_sum + 5'(RND);
    g_rnd = g_sum + 5'(RND);
    b_rnd = b_sum + 4'(RND);
    r_acc_d = sample_vld ? r_sum : r_acc_q;
    g_acc_d = sample_vld ? g_sum : g_acc_q;
    b_acc_d = sample_vld ? b_sum : b_acc_q;
    pix_vld = sample_vld & last;
    pix_dat = {r_rnd[4:2], g_rnd[4:2], b_rnd[3:2]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_q <= '0;
      g_acc_q <= '0;
      b_acc_q <= '0;
    end else begin
      r_acc_q <= r_acc_d;
      g_acc_q <= g_acc_d;
      b_acc_q <= b_acc_d;
    end
  end

endmodule

// File: rtl/rom_to_ram_avg2x2.sv
// Framebuffer fill: reads a full-res RGB332 image from ROM, writes its 2x2 average in raster order.
// Latency: pixel n written at edge 3+ROM_LAT+4n after the start edge; done at 4N+ROM_LAT.
// Backpressure: none; ROM read one address per cycle, RAM write port always accepts.
// Ports: clk, reset (sync, active-high), start (level); rom_addr/rom_data ROM read
//        port; ram_wraddr/ram_data/ram_wren framebuffer write port; busy, done status.
module rom_to_ram_avg2x2
  import fb_pkg::*;
#(
  parameter int SRC_W   = 320,
  parameter int SRC_H   = 240,
  parameter int ROM_LAT = 2,
  parameter int ADDR_W  = fb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [7:0]        ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done
);

  localparam int DST_W = SRC_W / 2;
  localparam int DST_H = SRC_H / 2;
  localparam int DX_W  = (DST_W > 1) ? $clog2(DST_W) : 1;
  localparam int DY_W  = (DST_H > 1) ? $clog2(DST_H) : 1;

  fsm_state_t               state_q, state_d;
  logic [DX_W-1:0]          dx_q, dx_d;
  logic [DY_W-1:0]          dy_q, dy_d;
  logic [1:0]               ph_q, ph_d;
  logic [ADDR_W-1:0]        b_q, b_d;
  logic [ADDR_W-1:0]        rom_addr_q, rom_addr_d;
  logic [ROM_LAT-1:0]       pv_q, pv_d;
  logic [ROM_LAT-1:0][1:0]  pp_q, pp_d;
  logic [ADDR_W-1:0]        wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0]        ram_wraddr_q, ram_wraddr_d;
  logic [7:0]               ram_data_q, ram_data_d;
  logic                     ram_wren_q, ram_wren_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic                     accept, issue, row_end, last_smp;
  logic [ADDR_W-1:0]        offs;
  logic                     ret_vld;
  logic [1:0]               ret_ph;
  logic                     pix_vld;
  logic [7:0]               pix_dat;

  // The tail of the valid/phase pipe lines up with the ROM word now on rom_data
  assign ret_vld = pv_q[ROM_LAT-1];
  assign ret_ph  = pp_q[ROM_LAT-1];

  rgb332_avg4 u_avg (
    .clk        (clk),
    .reset      (reset),
    .sample_vld (ret_vld),
    .sample     (rom_data),
    .clear      (ret_ph == 2'd0),
    .last       (ret_ph == 2'd3),
    .pix_vld    (pix_vld),
    .pix_dat    (pix_dat)
  );

  always_comb begin
    state_d      = state_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    ph_d         = ph_q;
    b_d          = b_q;
    rom_addr_d   = rom_addr_q;
    wr_cnt_d     = wr_cnt_q;
    ram_wraddr_d = ram_wraddr_q;
    ram_data_d   = ram_data_q;
    ram_wren_d   = 1'b0;

    accept   = start && (state_q == IDLE || state_q == DONE);
    issue    = accept || (state_q == READ);
    row_end  = (dx_q == DX_W'(DST_W - 1));
    last_smp = (ph_q == 2'd3) && row_end && (dy_q == DY_W'(DST_H - 1));

    // Sample order within a block: b, b+1, b+SRC_W, b+SRC_W+1
    case (ph_q)
      2'd0:    offs = '0;
      2'd1:    offs = ADDR_W'(1);
      2'd2:    offs = ADDR_W'(SRC_W);
      default: offs = ADDR_W'(SRC_W + 1);
    endcase

    pv_d[0] = issue;
    pp_d[0] = ph_q;
    for (int i = 1; i < ROM_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pp_d[i] = pp_q[i-1];
    end

    if (accept) begin
      state_d  = READ;
      wr_cnt_d = '0;
    end

    // Counters always point at the next sample to issue, so the start edge
    // already drives sample 0 onto rom_addr.
    if (issue) begin
      rom_addr_d = b_q + offs;
      ph_d       = ph_q + 2'd1;
      if (ph_q == 2'd3) begin
        if (last_smp) begin
          dx_d    = '0;
          dy_d    = '0;
          b_d     = '0;
          state_d = DRAIN;
        end else if (row_end) begin
          // skip the odd source row already covered by the +SRC_W samples
          dx_d = '0;
          dy_d = dy_q + DY_W'(1);
          b_d  = b_q + ADDR_W'(SRC_W + 2);
        end else begin
          dx_d = dx_q + DX_W'(1);
          b_d  = b_q + ADDR_W'(2);
        end
      end
    end

    if (pix_vld) begin
      ram_wren_d   = 1'b1;
      ram_data_d   = pix_dat;
      ram_wraddr_d = wr_cnt_q;
      wr_cnt_d     = wr_cnt_q + ADDR_W'(1);
    end

    // Final write is on the bus and nothing is left in flight
    if (state_q == DRAIN && ram_wren_q && pv_q == '0) begin
      state_d = DONE;
    end

    busy_d = (state_d == READ) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      dx_q         <= '0;
      dy_q         <= '0;
      ph_q         <= '0;
      b_q          <= '0;
      rom_addr_q   <= '0;
      pv_q         <= '0;
      pp_q         <= '0;
      wr_cnt_q     <= '0;
      ram_wraddr_q <= '0;
      ram_data_q   <= '0;
      ram_wren_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      ph_q         <= ph_d;
      b_q          <= b_d;
      rom_addr_q   <= rom_addr_d;
      pv_q         <= pv_d;
      pp_q         <= pp_d;
      wr_cnt_q     <= wr_cnt_d;
      ram_wraddr_q <= ram_wraddr_d;
      ram_data_q   <= ram_data_d;
      ram_wren_q   <= ram_wren_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign ram_wraddr = ram_wraddr_q;
  assign ram_data   = ram_data_q;
  assign ram_wren   = ram_wren_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
